mem_bus_initiator: RTL and testbench

- Command-driven bus master for the picorv32 native memory interface. It is the initiator counterpart of the torture-bench memory responder.
- It turns a command stream into single mem_valid/mem_ready transactions and drives the mem_la_* look-ahead signals one cycle ahead, as the core does.
- It returns read data and status on a response stream.
- It lets the team exercise memories, bridges and peripherals without a CPU in the loop.

---
 rtl/mem_bus_initiator_if.sv | 54 +++++
 rtl/mem_bus_initiator.sv | 146 ++++++++++++++
 tb/tb_mem_bus_initiator.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_initiator_if.sv
`default_nettype none
// ============================================================================
// mem_bus_initiator_if
// Command, response and picorv32 native-bus signals of the bus initiator.
// Revision: 1.0
// ============================================================================
interface mem_bus_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_instr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_la_read;
  logic        mem_la_write;
  logic [31:0] mem_la_addr;
  logic [31:0] mem_la_wdata;
  logic [3:0]  mem_la_wstrb;

  modport master (
    input  cmd_valid, cmd_write, cmd_instr, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_instr, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_initiator.sv
`default_nettype none
// ============================================================================
// mem_bus_initiator
// Command-driven picorv32 native-bus master with look-ahead phase and timeout.
// Revision: 1.0
// ============================================================================
module mem_bus_initiator #(
  parameter int LA_ENABLE = 1,
  parameter int TIMEOUT   = 1023
) (
  input  wire                 clk,
  input  wire                 resetn,
  mem_bus_initiator_if.master bus,
  output logic                busy,
  output logic [31:0]         txn_count
);

  localparam bit          C_LA_EN    = (LA_ENABLE != 0);
  localparam bit          C_TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] C_TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LA   = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_write;
  logic        r_instr;
  logic [31:0] r_tmo;
  logic [31:0] r_txn;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_accept;
  logic        w_illegal;
  logic        w_done;
  logic        w_timeout;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    w_accept         = 1'b0;
    w_illegal        = 1'b0;
    w_done           = 1'b0;
    w_timeout        = 1'b0;
    bus.cmd_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.mem_valid    = 1'b0;
    bus.mem_la_read  = 1'b0;
    bus.mem_la_write = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept  = 1'b1;
          w_illegal = bus.cmd_write && (bus.cmd_wstrb == 4'b0000);
          if (w_illegal)    w_next = S_RESP;
          else if (C_LA_EN) w_next = S_LA;
          else              w_next = S_WAIT;
        end
      end
      S_LA: begin
        bus.mem_la_read  = !r_write;
        bus.mem_la_write = r_write;
        w_next           = S_WAIT;
      end
      S_WAIT: begin
        bus.mem_valid = 1'b1;
        w_done        = bus.mem_ready;
        // completion on the same edge as the last allowed cycle wins over abort
        w_timeout     = C_TMO_EN && !bus.mem_ready && (r_tmo == C_TMO_LAST);
        if (w_done || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_write     <= 1'b0;
      r_instr     <= 1'b0;
      r_tmo       <= 32'd0;
      r_txn       <= 32'd0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.cmd_addr & ~32'h0000_0003;
        r_wdata <= bus.cmd_wdata;
        r_write <= bus.cmd_write;
        r_wstrb <= bus.cmd_write ? bus.cmd_wstrb : 4'b0000;
        r_instr <= bus.cmd_write ? 1'b0 : bus.cmd_instr;
        r_tmo   <= 32'd0;
        if (w_illegal) begin
          r_rsp_rdata <= 32'd0;
          r_rsp_err   <= 1'b1;
        end
      end
      if (w_done) begin
        r_rsp_rdata <= r_write ? 32'd0 : bus.mem_rdata;
        r_rsp_err   <= 1'b0;
        r_txn       <= r_txn + 32'd1;
      end else if (w_timeout) begin
        r_rsp_rdata <= 32'd0;
        r_rsp_err   <= 1'b1;
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + 32'd1;
      end
    end
  end

  // Bus and look-ahead payloads present the latched command at all times;
  // only the strobes/valid qualify them.
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.mem_wstrb    = r_wstrb;
  assign bus.mem_instr    = r_instr;
  assign bus.mem_la_addr  = r_addr;
  assign bus.mem_la_wdata = r_wdata;
  assign bus.mem_la_wstrb = r_wstrb;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_err      = r_rsp_err;
  assign busy             = (r_state != S_IDLE);
  assign txn_count        = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_initiator.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_initiator
// Directed and randomised checks of mem_bus_initiator against a shadow memory.
// Revision: 1.0
// ============================================================================
module tb_mem_bus_initiator;

  logic        clk = 1'b0;
  logic        resetn;
  logic        busy;
  logic [31:0] txn_count;
  int          n_tests = 0;
  int          n_fail  = 0;

  mem_bus_initiator_if bus ();

  mem_bus_initiator #(.LA_ENABLE(1), .TIMEOUT(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .busy      (busy),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic send_cmd(input logic w, input logic ins, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_instr = ins;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_wstrb = ws;
  endtask

  // Responder memory (driven from the bus) and expected memory (from commands)
  logic [31:0] resp_mem  [64];
  logic [31:0] model_mem [64];

  initial begin
    logic [31:0] xs;
    logic [31:0] a, wd, exp_rd;
    logic [3:0]  ws;
    logic        w, ins, done;
    int          wcnt, cnt;

    resetn        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_instr = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.cmd_wstrb = 4'd0;
    bus.rsp_ready = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;

    // Reset state
    repeat (5) tick();
    resetn = 1'b1;
    tick();
    check_b("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check_b("rst_mem_valid", bus.mem_valid, 1'b0);
    check_b("rst_la_read",   bus.mem_la_read, 1'b0);
    check_b("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_b("rst_busy",      busy, 1'b0);
    check  ("rst_txn",       txn_count, 32'd0);

    // Read answered from look-ahead
    send_cmd(1'b0, 1'b1, 32'h0000_0013, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    check_b("rd_la_read",   bus.mem_la_read, 1'b1);
    check  ("rd_la_addr",   bus.mem_la_addr, 32'h10);
    check_b("rd_la_valid0", bus.mem_valid, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    check_b("rd_mem_valid", bus.mem_valid, 1'b1);
    check_b("rd_mem_instr", bus.mem_instr, 1'b1);
    check  ("rd_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check  ("rd_mem_addr",  bus.mem_addr, 32'h10);
    check_b("rd_la_off",    bus.mem_la_read, 1'b0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    check_b("rd_rsp_valid", bus.rsp_valid, 1'b1);
    check  ("rd_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check_b("rd_rsp_err",   bus.rsp_err, 1'b0);
    check  ("rd_txn",       txn_count, 32'd1);
    check_b("rd_valid_off", bus.mem_valid, 1'b0);
    tick();
    bus.rsp_ready = 1'b0;
    check_b("rd_idle_ready", bus.cmd_ready, 1'b1);

    // Write with 4 wait cycles and a stalled response
    send_cmd(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_1234, 4'b0101);
    tick();
    bus.cmd_valid = 1'b0;
    check_b("wr_la_write", bus.mem_la_write, 1'b1);
    check_b("wr_la_read",  bus.mem_la_read, 1'b0);
    check  ("wr_la_wdata", bus.mem_la_wdata, 32'hA5A5_1234);
    check  ("wr_la_wstrb", 32'(bus.mem_la_wstrb), 32'h5);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_b("wr_mem_valid", bus.mem_valid, 1'b1);
      check  ("wr_mem_addr",  bus.mem_addr, 32'h20);
      check  ("wr_mem_wdata", bus.mem_wdata, 32'hA5A5_1234);
      check  ("wr_mem_wstrb", 32'(bus.mem_wstrb), 32'h5);
      check_b("wr_mem_instr", bus.mem_instr, 1'b0);
      if (i == 4) bus.mem_ready = 1'b1;
      tick();
    end
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_b("wr_rsp_valid", bus.rsp_valid, 1'b1);
      check  ("wr_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_b("wr_rsp_err",   bus.rsp_err, 1'b0);
      check_b("wr_valid_off", bus.mem_valid, 1'b0);
      check_b("wr_no_cmd",    bus.cmd_ready, 1'b0);
      if (i == 3) bus.rsp_ready = 1'b1;
      tick();
    end
    bus.rsp_ready = 1'b0;
    check_b("wr_rsp_done", bus.rsp_valid, 1'b0);
    check  ("wr_txn",      txn_count, 32'd2);

    // Timeout: responder never ready
    send_cmd(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    cnt = 0;
    while (bus.mem_valid && cnt < 20) begin
      cnt++;
      tick();
    end
    check  ("tmo_cycles",  32'(cnt), 32'd8);
    check_b("tmo_rsp_valid", bus.rsp_valid, 1'b1);
    check_b("tmo_rsp_err", bus.rsp_err, 1'b1);
    check  ("tmo_rdata",   bus.rsp_rdata, 32'd0);
    check  ("tmo_txn",     txn_count, 32'd2);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Illegal write (no byte enables)
    send_cmd(1'b1, 1'b0, 32'h0000_0080, 32'h1234_5678, 4'b0000);
    tick();
    bus.cmd_valid = 1'b0;
    check_b("ill_mem_valid", bus.mem_valid, 1'b0);
    check_b("ill_la_write",  bus.mem_la_write, 1'b0);
    check_b("ill_rsp_valid", bus.rsp_valid, 1'b1);
    check_b("ill_rsp_err",   bus.rsp_err, 1'b1);
    check  ("ill_rdata",     bus.rsp_rdata, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check  ("ill_txn",       txn_count, 32'd2);
    check_b("ill_cmd_ready", bus.cmd_ready, 1'b1);

    // Randomised traffic against a shadow memory
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    for (int k = 0; k < 64; k++) begin
      resp_mem[k]  = $urandom;
      model_mem[k] = resp_mem[k];
    end
    xs = $urandom | 32'd1;
    for (int n = 0; n < 1000; n++) begin
      w   = 1'($urandom_range(0, 1));
      ins = 1'($urandom_range(0, 1));
      a   = $urandom & 32'h0000_00FF;
      wd  = $urandom;
      ws  = w ? 4'($urandom_range(1, 15)) : 4'($urandom);
      exp_rd = w ? 32'd0 : model_mem[a[7:2]];
      send_cmd(w, ins, a, wd, ws);
      tick();
      bus.cmd_valid = 1'b0;
      done = 1'b0;
      wcnt = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        xs = xs32(xs);
        bus.mem_rdata = resp_mem[bus.mem_addr[7:2]];
        if (bus.mem_valid) begin
          bus.mem_ready = xs[0] | (wcnt >= 4);
          wcnt++;
          if (bus.mem_ready && bus.mem_wstrb != 4'b0000)
            resp_mem[bus.mem_addr[7:2]] = merge(resp_mem[bus.mem_addr[7:2]],
                                                bus.mem_wdata, bus.mem_wstrb);
        end else begin
          bus.mem_ready = xs[1];
        end
        bus.rsp_ready = xs[2];
        if (bus.rsp_valid && bus.rsp_ready) begin
          check_b("rnd_err",   bus.rsp_err, 1'b0);
          check  ("rnd_rdata", bus.rsp_rdata, exp_rd);
          done = 1'b1;
        end
        tick();
      end
      bus.mem_ready = 1'b0;
      bus.rsp_ready = 1'b0;
      if (!done) check_b("rnd_no_response", done, 1'b1);
      if (w) model_mem[a[7:2]] = merge(model_mem[a[7:2]], wd, ws);
    end
    check("rnd_txn", txn_count, 32'd1000);

    // Reset pulsed during WAIT
    send_cmd(1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check_b("rstw_in_wait", bus.mem_valid, 1'b1);
    resetn = 1'b0;
    tick();
    check_b("rstw_mem_valid", bus.mem_valid, 1'b0);
    check_b("rstw_rsp_valid", bus.rsp_valid, 1'b0);
    check_b("rstw_busy",      busy, 1'b0);
    check  ("rstw_txn",       txn_count, 32'd0);
    resetn = 1'b1;
    tick();
    check_b("rstw_cmd_ready", bus.cmd_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
